// File: rtl/crc_block_packer.sv
// Byte-stream framer: packs 8 bytes into a 64-bit block, computes CRC-8 (poly 0x07)
// one bit per clock, strobes the result out, then freezes for a guard interval.
module crc_block_packer #(
  parameter int unsigned HOLD_CYCLES = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        abort,
  output logic [0:63] data_out,
  output logic [7:0]  crc_out,
  output logic        set,
  output logic        busy
);

  localparam int unsigned BYTE_CNT_W = 3;
  localparam int unsigned BIT_CNT_W  = 6;
  localparam int unsigned HOLD_W     = 8;
  localparam int unsigned CRC_W      = 8;

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_CALC    = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]            state_q,    state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [CRC_W-1:0]      crc_q,      crc_d;
  logic [0:63]           work_q,     work_d;
  logic [0:63]           data_d;
  logic [CRC_W-1:0]      crc_out_d;
  logic                  set_d;

  // One MSB-first step of the 0x07 polynomial, no reflection.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    crc_d      = crc_q;
    work_d     = work_q;
    data_d     = data_out;
    crc_out_d  = crc_out;
    set_d      = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (abort) begin
          byte_cnt_d = '0;
          work_d     = '0;
        end else if (byte_valid) begin
          work_d     = {work_q[8:63], byte_in};
          byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
          if (byte_cnt_q == BYTE_CNT_W'(7)) begin
            state_d   = S_CALC;
            crc_d     = '0;
            bit_cnt_d = '0;
          end
        end
      end
      S_CALC: begin
        crc_d     = crc8_step(crc_q, work_q[bit_cnt_q]);
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == BIT_CNT_W'(63)) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        data_d     = work_q;
        crc_out_d  = crc_q;
        set_d      = 1'b1;
        hold_cnt_d = HOLD_W'(HOLD_CYCLES);
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d    = S_COLLECT;
          byte_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_COLLECT;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      crc_q      <= '0;
      work_q     <= '0;
      data_out   <= '0;
      crc_out    <= '0;
      set        <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      crc_q      <= crc_d;
      work_q     <= work_d;
      data_out   <= data_d;
      crc_out    <= crc_out_d;
      set        <= set_d;
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign byte_ready = (state_q == S_COLLECT);
  assign busy       = (state_q != S_COLLECT);

endmodule

// File: tb/tb_crc_block_packer.sv
// Scoreboard bench for crc_block_packer: a byte-level model predicts each block and
// its CRC (by polynomial long division); a monitor checks every set strobe and HOLD behaviour.
module tb_crc_block_packer;

  localparam int unsigned H = 3;
  localparam int unsigned READY_LOW = 66 + H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        abort = 1'b0;
  logic        byte_ready;
  logic [0:63] data_out;
  logic [7:0]  crc_out;
  logic        set;
  logic        busy;

  crc_block_packer #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .abort(abort), .data_out(data_out),
    .crc_out(crc_out), .set(set), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  crc;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  coll_q[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        ovr_valid = 1'b0;
  logic [63:0] ovr_data;
  logic [7:0]  ovr_crc;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference CRC: remainder of (data * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [63:0] d);
    logic [71:0] r;
    logic [71:0] p;
    r = {d, 8'h00};
    for (int i = 71; i >= 8; i--) begin
      if (r[i]) begin
        p = 72'h107;
        r = r ^ (p << (i - 8));
      end
    end
    return r[7:0];
  endfunction

  // One driven cycle; model updates from what the DUT will see on the next edge.
  task automatic step(input logic v, input logic [7:0] b, input logic a, output logic acc);
    exp_t e;
    logic [63:0] d;
    byte_valid = v;
    byte_in    = b;
    abort      = a;
    @(negedge clk);
    acc = 1'b0;
    if (byte_ready && a) begin
      coll_q.delete();
    end else if (byte_ready && v) begin
      acc = 1'b1;
      coll_q.push_back(b);
      if (coll_q.size() == 8) begin
        d = '0;
        foreach (coll_q[i]) d = (d << 8) | 64'(coll_q[i]);
        e.data = d;
        e.crc  = ref_crc(d);
        if (ovr_valid) begin
          e.data = ovr_data;
          e.crc  = ovr_crc;
          ovr_valid = 1'b0;
        end
        e.cyc = cyc + 1 + 65;
        exp_q.push_back(e);
        coll_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, acc);
  endtask

  // Holds the byte with valid high until it is accepted, bounded.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      step(1'b1, b, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h not accepted within 500 cycles", b);
    end
  endtask

  task automatic send_block(input logic [63:0] blk, input logic [7:0] crc);
    logic [63:0] t;
    ovr_valid = 1'b1;
    ovr_data  = blk;
    ovr_crc   = crc;
    t = blk;
    for (int i = 0; i < 8; i++) begin
      send_byte(t[63:56]);
      t = t << 8;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [63:0] dv;
    dv = data_out;
    checks += 5;
    if (dv != 64'h0) begin errors++; $display("FAIL %s data_out got=%h want=0", tag, dv); end
    if (crc_out != 8'h00) begin errors++; $display("FAIL %s crc_out got=%h want=00", tag, crc_out); end
    if (set !== 1'b0) begin errors++; $display("FAIL %s set got=%b want=0", tag, set); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got=%b want=0", tag, busy); end
    if (byte_ready !== 1'b1) begin errors++; $display("FAIL %s byte_ready got=%b want=1", tag, byte_ready); end
  endtask

  // Monitor: scoreboard on set, output stability, ready-low duration, busy decode.
  logic [63:0] prev_data = '0;
  logic [7:0]  prev_crc = '0;
  logic        prev_set = 1'b0;
  int          low_run = 0;
  logic        run_valid = 1'b0;

  always @(negedge clk) begin
    logic [63:0] dv;
    exp_t e;
    dv = data_out;
    if (!rst_n) begin
      low_run   = 0;
      run_valid = 1'b0;
      prev_set  = 1'b0;
    end else begin
      if (set) begin
        checks++;
        if (prev_set) begin errors++; $display("FAIL set_width set high two cycles at cyc=%0d", cyc); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_set at cyc=%0d data=%h crc=%h", cyc, dv, crc_out);
        end else begin
          e = exp_q.pop_front();
          checks += 3;
          if (dv != e.data) begin errors++; $display("FAIL data_out got=%h want=%h", dv, e.data); end
          if (crc_out != e.crc) begin errors++; $display("FAIL crc_out got=%h want=%h (data=%h)", crc_out, e.crc, e.data); end
          if (cyc != e.cyc) begin errors++; $display("FAIL set_latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc); end
        end
      end else begin
        checks++;
        if (dv != prev_data || crc_out != prev_crc) begin
          errors++;
          $display("FAIL output_stable data got=%h was=%h crc got=%h was=%h", dv, prev_data, crc_out, prev_crc);
        end
      end
      checks++;
      if (busy == byte_ready) begin errors++; $display("FAIL busy_decode busy=%b byte_ready=%b", busy, byte_ready); end
      if (!byte_ready) begin
        if (low_run == 0) run_valid = 1'b1;
        low_run++;
      end else begin
        if (run_valid) begin
          checks++;
          if (low_run != int'(READY_LOW)) begin
            errors++;
            $display("FAIL ready_low_cycles got=%0d want=%0d", low_run, READY_LOW);
          end
        end
        low_run   = 0;
        run_valid = 1'b0;
      end
      prev_set = set;
    end
    prev_data = dv;
    prev_crc  = crc_out;
  end

  initial begin
    logic acc;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
    @(posedge clk);
    #1;

    // Directed CRC vectors.
    send_block(64'h0000000000000001, 8'h07);
    send_block(64'h0000000000000080, 8'h89);
    send_block(64'h0000000000000100, 8'h15);
    send_block(64'h0000000000000000, 8'h00);

    // Back-to-back with byte_valid held high across CALC/HOLD.
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    idle(80);

    // Abort with a coincident valid byte drops the partial block.
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i));
    step(1'b1, 8'hAA, 1'b1, acc);
    ovr_valid = 1'b1;
    ovr_data  = 64'h0102030405060708;
    ovr_crc   = ref_crc(64'h0102030405060708);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));

    // Gapped valid: one byte every third cycle, valid stays up during HOLD.
    for (int blk = 0; blk < 5; blk++) begin
      for (int i = 0; i < 8; i++) begin
        send_byte(8'($urandom));
        idle(2);
      end
    end

    // Random gaps and occasional aborts.
    for (int blk = 0; blk < 5; blk++) begin
      for (int i = 0; i < 8; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 15) == 0) step(1'b1, b, 1'b1, acc);
        send_byte(b);
        idle(int'($urandom_range(0, 2)));
      end
    end
    idle(100);

    // Reset in the middle of CALC: outputs clear at once, no set afterwards.
    for (int i = 0; i < 8; i++) send_byte(8'($urandom) | 8'h01);
    idle(20);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_calc");
    exp_q.delete();
    coll_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(120);

    // One more block after recovery.
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    idle(150);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_set pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
